// File: rtl/trng_word_packer.sv
// Packs raw entropy bits into WORD_W-bit words through an optional von Neumann debiaser into a FWFT word FIFO.
// Words appear one cycle after their last bit; a full FIFO drops new words (sticky overflow), total failure locks out until reset.
module trng_word_packer #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int VN_EN      = 1
) (
    input  logic                          clk,
    input  logic                          rst_i,
    input  logic                          rnd_bit,
    input  logic                          bit_valid,
    input  logic                          ht_error,
    input  logic                          ht_total_failure,
    output logic [WORD_W-1:0]             word_data,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          alarm
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(WORD_W);

    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W:0]    r_level;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WORD_W-1:0] r_partial;
    logic              r_pending;
    logic              r_first;
    logic              r_overflow;
    logic              r_alarm;

    logic              w_qual;
    logic              w_discard;
    logic              w_emit;
    logic              w_emit_bit;
    logic [WORD_W-1:0] w_word;
    logic              w_done;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_push_en;

    assign w_discard = bit_valid && ht_error && !r_alarm;
    assign w_qual    = bit_valid && !ht_error && !r_alarm;

    // Debiaser: the second sample of an unequal pair releases the first sample.
    always_comb begin
        w_emit     = 1'b0;
        w_emit_bit = rnd_bit;
        if (VN_EN == 0) begin
            w_emit = w_qual;
        end else begin
            w_emit     = w_qual && r_pending && (r_first != rnd_bit);
            w_emit_bit = r_first;
        end
    end

    always_comb begin
        w_word            = r_partial;
        w_word[r_bit_cnt] = w_emit_bit;
    end

    assign w_done     = w_emit && (r_bit_cnt == CNT_W'(WORD_W - 1));
    assign w_full     = (r_level == (PTR_W + 1)'(FIFO_DEPTH));
    assign word_valid = (r_level != '0) && !r_alarm;
    assign w_pop      = word_valid && word_ready;
    assign w_push     = w_done && (!w_full || w_pop);
    assign w_push_en  = w_push && !ht_total_failure && !rst_i;

    assign word_data  = word_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign alarm      = r_alarm;

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= '0;
            r_bit_cnt  <= '0;
            r_partial  <= '0;
            r_pending  <= 1'b0;
            r_first    <= 1'b0;
            r_overflow <= 1'b0;
            r_alarm    <= 1'b0;
        end else if (!r_alarm) begin
            if (ht_total_failure) begin
                // Lockout wins over any same-cycle push or pop.
                r_alarm   <= 1'b1;
                r_rd_ptr  <= '0;
                r_wr_ptr  <= '0;
                r_level   <= '0;
                r_bit_cnt <= '0;
                r_partial <= '0;
                r_pending <= 1'b0;
            end else begin
                if (w_discard) begin
                    r_pending <= 1'b0;
                    r_bit_cnt <= '0;
                    r_partial <= '0;
                end else if (w_qual && (VN_EN != 0)) begin
                    r_pending <= !r_pending;
                    if (!r_pending) begin
                        r_first <= rnd_bit;
                    end
                end

                if (w_emit) begin
                    if (w_done) begin
                        r_bit_cnt <= '0;
                        r_partial <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_partial <= w_word;
                    end
                end

                if (w_done && !w_push) begin
                    r_overflow <= 1'b1;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end

                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + 1'b1;
                    2'b01:   r_level <= r_level - 1'b1;
                    default: r_level <= r_level;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trng_word_packer.sv
// Drives a pass-through and a debiasing packer with the same stimulus and checks both against a list-based model.
module tb_trng_word_packer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bv = 1'b0, b = 1'b0, err = 1'b0, tf = 1'b0, rdy = 1'b0;

    logic [7:0] raw_wd, vn_wd;
    logic       raw_wv, vn_wv, raw_ovf, vn_ovf, raw_alm, vn_alm;
    logic [2:0] raw_lvl, vn_lvl;
    wire [13:0] raw_vec = {raw_wd, raw_wv, raw_lvl, raw_ovf, raw_alm};
    wire [13:0] vn_vec  = {vn_wd, vn_wv, vn_lvl, vn_ovf, vn_alm};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trng_word_packer #(.WORD_W(8), .FIFO_DEPTH(4), .VN_EN(0)) u_raw (
        .clk(clk), .rst_i(rst), .rnd_bit(b), .bit_valid(bv), .ht_error(err),
        .ht_total_failure(tf), .word_data(raw_wd), .word_valid(raw_wv),
        .word_ready(rdy), .fifo_level(raw_lvl), .overflow(raw_ovf), .alarm(raw_alm));

    trng_word_packer #(.WORD_W(8), .FIFO_DEPTH(4), .VN_EN(1)) u_vn (
        .clk(clk), .rst_i(rst), .rnd_bit(b), .bit_valid(bv), .ht_error(err),
        .ht_total_failure(tf), .word_data(vn_wd), .word_valid(vn_wv),
        .word_ready(rdy), .fifo_level(vn_lvl), .overflow(vn_ovf), .alarm(vn_alm));

    // Reference model: index 0 is pass-through, 1 is debiased. FIFO is an ordered list, head at slot 0.
    logic [7:0] m_words [2][4];
    int         m_cnt [2];
    logic [7:0] m_part [2];
    int         m_nb [2];
    bit         m_pend [2], m_first [2], m_ovf [2], m_alm [2];

    task automatic model_step(input int k);
        bit pop, emit, eb, done;
        logic [7:0] w;
        emit = 0; eb = 0; done = 0; w = 0;
        if (rst) begin
            m_cnt[k] = 0; m_part[k] = 0; m_nb[k] = 0;
            m_pend[k] = 0; m_first[k] = 0; m_ovf[k] = 0; m_alm[k] = 0;
        end else if (!m_alm[k]) begin
            pop = (m_cnt[k] > 0) && rdy;
            if (tf) begin
                m_alm[k] = 1; m_cnt[k] = 0; m_part[k] = 0; m_nb[k] = 0; m_pend[k] = 0;
            end else begin
                if (bv && err) begin
                    m_pend[k] = 0; m_part[k] = 0; m_nb[k] = 0;
                end else if (bv) begin
                    if (k == 0) begin
                        emit = 1; eb = b;
                    end else if (!m_pend[k]) begin
                        m_pend[k] = 1; m_first[k] = b;
                    end else begin
                        m_pend[k] = 0;
                        if (m_first[k] != b) begin emit = 1; eb = m_first[k]; end
                    end
                end
                if (emit) begin
                    m_part[k] = m_part[k] + (8'(eb) << m_nb[k]);
                    m_nb[k]++;
                    if (m_nb[k] == 8) begin
                        done = 1; w = m_part[k]; m_part[k] = 0; m_nb[k] = 0;
                    end
                end
                if (pop) begin
                    for (int i = 0; i < 3; i++) m_words[k][i] = m_words[k][i+1];
                    m_cnt[k]--;
                end
                if (done) begin
                    if (m_cnt[k] < 4) begin m_words[k][m_cnt[k]] = w; m_cnt[k]++; end
                    else m_ovf[k] = 1;
                end
            end
        end
    endtask

    function automatic logic [13:0] exp_vec(input int k);
        logic wv;
        wv = (m_cnt[k] > 0) && !m_alm[k];
        return {wv ? m_words[k][0] : 8'h00, wv, 3'(m_cnt[k]), m_ovf[k], m_alm[k]};
    endfunction

    task automatic step(input bit v, input bit bb, input bit e, input bit t, input bit r);
        bv = v; b = bb; err = e; tf = t; rdy = r;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] w, input bit r_last);
        logic [7:0] x;
        x = w;
        for (int i = 0; i < 8; i++) step(1, x[i], 0, 0, (i == 7) ? r_last : 1'b0);
    endtask

    task automatic do_reset();
        rst = 1; step(0, 0, 0, 0, 0); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        rst = 0;
        checks++;
        if (raw_vec !== 14'h0) begin errors++; $display("FAIL reset_raw got=%h exp=%h", raw_vec, 14'h0); end
        checks++;
        if (vn_vec !== 14'h0) begin errors++; $display("FAIL reset_vn got=%h exp=%h", vn_vec, 14'h0); end
    endtask

    task automatic test_passthrough();
        logic [7:0] pat;
        pat = 8'b0100_1101;
        do_reset();
        for (int i = 0; i < 7; i++) step(1, pat[i], 0, 0, 0);
        checks++;
        if (raw_wv !== 1'b0) begin errors++; $display("FAIL pt_early_valid got=%b exp=0", raw_wv); end
        step(1, pat[7], 0, 0, 0);
        checks++;
        if ({raw_wv, raw_wd} !== {1'b1, 8'h4D}) begin
            errors++; $display("FAIL pt_word got=%b/%h exp=1/4d", raw_wv, raw_wd);
        end
        checks++;
        if (vn_vec !== exp_vec(1)) begin errors++; $display("FAIL pt_vn got=%h exp=%h", vn_vec, exp_vec(1)); end
    endtask

    task automatic test_vn_pairs();
        bit pairs [10][2];
        pairs = '{'{0,1}, '{1,1}, '{1,0}, '{0,0}, '{0,1},
                  '{1,0}, '{1,0}, '{1,0}, '{1,0}, '{1,0}};
        do_reset();
        for (int p = 0; p < 10; p++) begin
            step(1, pairs[p][0], 0, 0, 0);
            step(1, pairs[p][1], 0, 0, 0);
            if (p == 8) begin
                checks++;
                if (vn_wv !== 1'b0) begin errors++; $display("FAIL vn_early_valid got=%b exp=0", vn_wv); end
            end
        end
        checks++;
        if ({vn_wv, vn_wd} !== {1'b1, 8'hFA}) begin
            errors++; $display("FAIL vn_word got=%b/%h exp=1/fa", vn_wv, vn_wd);
        end
        checks++;
        if (raw_vec !== exp_vec(0)) begin errors++; $display("FAIL vn_raw got=%h exp=%h", raw_vec, exp_vec(0)); end
    endtask

    task automatic test_ht_error();
        logic [7:0] pat;
        pat = 8'hA5;
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(1, pat[i], 0, 0, 0);
        checks++;
        if (raw_wv !== 1'b0) begin errors++; $display("FAIL hte_early_valid got=%b exp=0", raw_wv); end
        step(1, pat[7], 0, 0, 0);
        checks++;
        if ({raw_wv, raw_wd} !== {1'b1, 8'hA5}) begin
            errors++; $display("FAIL hte_word got=%b/%h exp=1/a5", raw_wv, raw_wd);
        end
        checks++;
        if (vn_vec !== exp_vec(1)) begin errors++; $display("FAIL hte_vn got=%h exp=%h", vn_vec, exp_vec(1)); end
    endtask

    task automatic test_overflow();
        logic [7:0] w [6];
        for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(w[i], 0);
        checks++;
        if ({raw_lvl, raw_ovf, raw_wv, raw_wd} !== {3'd4, 1'b1, 1'b1, w[0]}) begin
            errors++; $display("FAIL ovf_full got=%0d/%b/%b/%h exp=4/1/1/%h", raw_lvl, raw_ovf, raw_wv, raw_wd, w[0]);
        end
        send_byte(w[5], 1);
        checks++;
        if ({raw_lvl, raw_ovf, raw_wd} !== {3'd4, 1'b1, w[1]}) begin
            errors++; $display("FAIL ovf_pushpop got=%0d/%b/%h exp=4/1/%h", raw_lvl, raw_ovf, raw_wd, w[1]);
        end
        checks++;
        if (vn_vec !== exp_vec(1)) begin errors++; $display("FAIL ovf_vn got=%h exp=%h", vn_vec, exp_vec(1)); end
    endtask

    task automatic test_alarm();
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
        step(1, 1, 0, 1, 1);
        checks++;
        if ({raw_alm, raw_lvl, raw_wv} !== {1'b1, 3'd0, 1'b0}) begin
            errors++; $display("FAIL alarm_set got=%b/%0d/%b exp=1/0/0", raw_alm, raw_lvl, raw_wv);
        end
        for (int i = 0; i < 24; i++) step(1, 1'($urandom), 0, 1'($urandom), 1'($urandom));
        checks++;
        if ({raw_alm, raw_lvl, raw_wv, raw_wd} !== {1'b1, 3'd0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL alarm_hold got=%b/%0d/%b/%h exp=1/0/0/00", raw_alm, raw_lvl, raw_wv, raw_wd);
        end
        checks++;
        if (vn_vec !== exp_vec(1)) begin errors++; $display("FAIL alarm_vn got=%h exp=%h", vn_vec, exp_vec(1)); end
        do_reset();
        checks++;
        if (raw_alm !== 1'b0) begin errors++; $display("FAIL alarm_clear got=%b exp=0", raw_alm); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'h3C, 0);
        send_byte(8'hC3, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        rst = 1;
        step(1, 1, 0, 1, 1);
        rst = 0;
        checks++;
        if (raw_vec !== 14'h0) begin errors++; $display("FAIL rstmid_raw got=%h exp=%h", raw_vec, 14'h0); end
        checks++;
        if (vn_vec !== 14'h0) begin errors++; $display("FAIL rstmid_vn got=%h exp=%h", vn_vec, 14'h0); end
        send_byte(8'h96, 0);
        checks++;
        if ({raw_wv, raw_wd, raw_lvl} !== {1'b1, 8'h96, 3'd1}) begin
            errors++; $display("FAIL rstmid_next got=%b/%h/%0d exp=1/96/1", raw_wv, raw_wd, raw_lvl);
        end
    endtask

    task automatic test_random();
        int bad_raw, bad_vn;
        bad_raw = 0; bad_vn = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0);
            checks++;
            if (raw_vec !== exp_vec(0)) begin
                errors++;
                if (bad_raw++ < 5) $display("FAIL rand_raw cyc=%0d got=%h exp=%h", c, raw_vec, exp_vec(0));
            end
            checks++;
            if (vn_vec !== exp_vec(1)) begin
                errors++;
                if (bad_vn++ < 5) $display("FAIL rand_vn cyc=%0d got=%h exp=%h", c, vn_vec, exp_vec(1));
            end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_vn_pairs();
        test_ht_error();
        test_overflow();
        test_alarm();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
